serial_adder: RTL

- Parametrised bit-serial ripple adder/subtractor.
- Reuses one full-adder cell and one carry flip-flop to add two WIDTH-bit operands, LSB first, one bit per clock.
- A start/busy/done handshake frames each operation. Results are registered and held until the next operation completes.
- Serves as an area-optimised arithmetic unit beside the combinational adder cells, wherever latency is acceptable.

---
 rtl/serial_adder.sv | 95 +++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial add/subtract using one full-adder cell and one carry flop, LSB first.
// Latency WIDTH clocks from the accept edge to done; no backpressure, start is ignored while busy.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  if (WIDTH < 2) begin : g_width_check
    $error("serial_adder: WIDTH must be at least 2");
  end

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             s_bit;
  logic             c_next;

  // Operands shift right each RUN cycle, so the adder cell always sees bit 0.
  assign s_bit  = opa[0] ^ opb[0] ^ carry;
  assign c_next = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      cnt   <= '0;
      carry <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        RUN: begin
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          carry <= c_next;
          acc   <= {s_bit, acc[WIDTH-1:1]};
          if (cnt == LAST) begin
            // carry still holds the carry into the MSB here
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= {s_bit, acc[WIDTH-1:1]};
            cout  <= c_next;
            ovf   <= carry ^ c_next;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
